// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word and instruction-fetch state encoding.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  localparam word_t WORD_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, a pending-redirect slot for redirects
// that arrive while the hazard unit is stalling, the RUN/HALTED state and a
// saturating count of valid fetches.
module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  output logic [31:0] instr_out,
  output logic [31:0] pcp4_out,
  output logic        fetch_valid,
  output logic        flush_out,
  output logic [31:0] fetch_count
);

  fetch_state_t state;
  word_t        pc;
  word_t        pend_pc;
  logic         pend_valid;
  word_t        count;
  logic         run;
  logic         redir_eff;

  // Branch targets are always word aligned; low bits from the ALU are dropped.
  function automatic word_t align_word(input word_t addr);
    return {addr[31:2], 2'b00};
  endfunction

  // Counter increment that sticks at the all-ones value instead of wrapping.
  function automatic word_t sat_inc(input word_t value);
    return (value == WORD_MAX) ? value : value + 32'd1;
  endfunction

  // Decode of the current-cycle fetch qualification and flush request.
  always_comb begin
    run         = (state == RUN);
    redir_eff   = redirect | (pend_valid & ~stall);
    fetch_valid = run & ihit & ~stall & ~halt & ~redir_eff;
    flush_out   = run & redir_eff & ~halt;
  end

  assign imemREN   = run;
  assign imemaddr  = pc;
  assign instr_out = imemload;
  assign pcp4_out  = pc + 32'd4;
  assign fetch_count = count;

  // PC / pending-redirect / state update, highest-priority event first.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= RUN;
      pc         <= PC_INIT;
      pend_pc    <= '0;
      pend_valid <= 1'b0;
    end else if (state == RUN) begin
      if (halt) begin
        state <= HALTED;
      end else if (redirect && stall) begin
        // Last redirect seen during a stall wins; pc waits for the stall to drop.
        pend_pc    <= align_word(redirect_pc);
        pend_valid <= 1'b1;
      end else if (redirect) begin
        pc         <= align_word(redirect_pc);
        pend_valid <= 1'b0;
      end else if (pend_valid && !stall) begin
        pc         <= pend_pc;
        pend_valid <= 1'b0;
      end else if (ihit && !stall) begin
        pc <= pc + 32'd4;
      end
    end
  end

  // Count every cycle that hands a real instruction to IF/ID.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count <= '0;
    end else if (fetch_valid) begin
      count <= sat_inc(count);
    end
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter SHALL be: PC_INIT, 32'h0000_0000, PC value loaded on reset.
REQ-002 CLK  in  1  clock; all state SHALL update on posedge CLK.
REQ-003 nRST  in  1  reset, asynchronous, active-low.
REQ-004 ihit  in  1  icache returns a valid instruction for imemaddr this cycle.
REQ-005 imemload  in  32  instruction word from icache.
REQ-006 stall  in  1  hazard unit hold request; PC SHALL NOT advance while high.
REQ-007 redirect  in  1  branch/jump resolved taken this cycle.
REQ-008 redirect_pc  in  32  target of redirect.
REQ-009 halt  in  1  halt instruction committed.
REQ-010 imemREN  out  1  icache read enable.
REQ-011 imemaddr  out  32  icache address, equal to the PC register.
REQ-012 instr_out  out  32  instruction to the IF/ID latch input.
REQ-013 pcp4_out  out  32  PC+4 to the IF/ID latch input.
REQ-014 fetch_valid  out  1  instr_out/pcp4_out are a real, non-squashed fetch this cycle.
REQ-015 flush_out  out  1  IF/ID latch flush request.
REQ-016 fetch_count  out  32  number of valid fetches since reset.

Function
REQ-017 States SHALL be RUN and HALTED; RUN->HALTED on halt=1 at a clock edge; HALTED SHALL be left only by reset.
REQ-018 imemREN SHALL be 1 in RUN and 0 in HALTED; imemaddr SHALL equal pc in both states.
REQ-019 instr_out SHALL equal imemload combinationally; pcp4_out SHALL equal pc+4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-020 pend_valid and pend_pc SHALL be held as internal registers for a redirect deferred by stall.
REQ-021 Effective redirect (redir_eff) SHALL be: redirect=1, or pend_valid=1 with stall=0.
REQ-022 fetch_valid SHALL be 1 only when state=RUN, ihit=1, stall=0, halt=0 and redir_eff=0; zero-latency, combinational.
REQ-023 flush_out SHALL be 1 in any RUN cycle where redir_eff=1 and halt=0, including cycles where stall=1.
REQ-024 PC update priority at each edge: halt (hold pc, go HALTED) > redirect with stall (pend_pc<=redirect_pc, pend_valid<=1, pc held) > redirect without stall (pc<=redirect_pc, pend_valid<=0) > pend_valid with stall=0 (pc<=pend_pc, pend_valid<=0) > ihit and stall=0 (pc<=pc+4) > hold.
REQ-025 A new redirect while pend_valid=1 SHALL overwrite pend_pc, last target wins.
REQ-026 Loaded targets SHALL have bits [1:0] forced to 2'b00.
REQ-027 Simultaneous ihit and redirect SHALL squash the returned instruction (fetch_valid=0) and load the target.
REQ-028 ihit=0 SHALL hold pc; a redirect during an icache miss SHALL retarget imemaddr at the next edge.
REQ-029 fetch_count SHALL increment by 1 on each edge with fetch_valid=1 and saturate at 32'hFFFF_FFFF.
REQ-030 In HALTED, redirect, stall and ihit SHALL be ignored, with fetch_valid=0 and flush_out=0.

Reset
REQ-031 nRST=0 SHALL immediately set pc=PC_INIT, state=RUN, pend_valid=0, pend_pc=0 and fetch_count=0.
REQ-032 Reset outputs: imemREN=1, imemaddr=PC_INIT, flush_out=0; fetch_valid follows ihit per REQ-022.
REQ-033 Reset asserted mid-miss or mid-pending-redirect SHALL discard all pending state with no residual flush.

Structure
REQ-034 word_t (32-bit) and the fetch_state_t enum {RUN, HALTED} SHALL reside in cpu_types_pkg; PC_INIT stays a module parameter.
REQ-035 No sub-module; single module holding the PC register, pending-redirect register, state register and counter.

Verification
REQ-036 Reset, then ihit=1 for 4 cycles -> imemaddr 0,4,8,C; fetch_valid=1 each cycle; fetch_count=4.
REQ-037 pc=0x10, ihit=1, redirect=1, redirect_pc=0x40 -> fetch_valid=0, flush_out=1; next imemaddr=0x40.
REQ-038 stall=1 with redirect to 0x80 then 0x90 two cycles later; stall drops -> pc held at stall; flush_out=1 on drop cycle; next imemaddr=0x90.
REQ-039 pc=0xFFFF_FFFC, ihit=1 -> pcp4_out=0; next imemaddr=0; redirect_pc=0x103 -> imemaddr=0x100.
REQ-040 halt=1 at pc=0x20 -> imemREN=0 and imemaddr=0x20 thereafter; later redirect/ihit -> no change.
REQ-041 nRST pulsed low during an icache miss with pend_valid=1 -> imemaddr=PC_INIT, fetch_count=0; no flush_out after release.
